// File: rtl/count_pkg.sv
// Shared definitions for the interval-counter scheduler: FSM encoding and
// default counter geometry.
package count_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int DEF_CNT_W     = 13;
    localparam int DEF_MAX_COUNT = 8191;
    localparam int ID_W          = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from
// ptr+1, wrapping at NUM_REQ.
module rr_arbiter
    import count_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [ID_W-1:0]    index,
    output logic               any_req
);

    logic [3:0] pos;
    logic       found;

    assign any_req = |req;

    always_comb begin
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        pos    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = {1'b0, ptr} + 4'(k);
            if (pos >= 4'(NUM_REQ))
                pos = pos - 4'(NUM_REQ);
            // Matching against every lane keeps the req select in range.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (4'(i) == pos)) begin
                    found     = 1'b1;
                    index     = ID_W'(i);
                    onehot[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/count_scheduler.sv
// Grants one shared interval counter to NUM_REQ requesters round-robin, starts
// it on a slow-tick rising edge and reports the captured count via valid/ready.
module count_scheduler
    import count_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_COUNT = DEF_MAX_COUNT
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               tick,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] stop,
    input  logic [CNT_W-1:0]   cnt_value,
    input  logic               cnt_full,
    output logic               cnt_clr,
    output logic               cnt_run,
    output logic [NUM_REQ-1:0] grant,
    output logic [CNT_W-1:0]   result,
    output logic [2:0]         result_id,
    output logic               result_sat,
    output logic               result_valid,
    input  logic               result_ready
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_COUNT);

    state_t             state, state_nxt;
    logic               tick_q;
    logic               tick_rise;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    id;
    logic [NUM_REQ-1:0] pick_oh;
    logic [ID_W-1:0]    pick_idx;
    logic               any_req;
    logic               own_req;
    logic               own_stop;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .onehot  (pick_oh),
        .index   (pick_idx),
        .any_req (any_req)
    );

    assign tick_rise = tick & ~tick_q;
    // Masking with grant avoids indexing req/stop with a wider id.
    assign own_req   = |(req & grant);
    assign own_stop  = |(stop & grant);
    assign result_id = id;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        cnt_run      = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE:   if (any_req) state_nxt = ARM;
            ARM: begin
                if (!own_req)       state_nxt = IDLE;
                else if (tick_rise) state_nxt = RUN;
            end
            RUN: begin
                cnt_run = 1'b1;
                if (!own_req)                 state_nxt = IDLE;
                else if (own_stop || cnt_full) state_nxt = REPORT;
            end
            REPORT: begin
                result_valid = 1'b1;
                if (result_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_q     <= 1'b0;
            ptr        <= ID_W'(NUM_REQ - 1);
            id         <= '0;
            grant      <= '0;
            cnt_clr    <= 1'b0;
            result     <= '0;
            result_sat <= 1'b0;
        end else begin
            tick_q  <= tick;
            cnt_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        id      <= pick_idx;
                        grant   <= pick_oh;
                        cnt_clr <= 1'b1;
                    end
                end
                ARM, RUN: begin
                    if (!own_req) begin
                        grant <= '0;
                        ptr   <= id;
                    end else if (state == RUN && (own_stop || cnt_full)) begin
                        // Stop wins over saturation but the value is then MAX.
                        result     <= (own_stop && !cnt_full) ? cnt_value : MAX_V;
                        result_sat <= ~own_stop;
                    end
                end
                REPORT: begin
                    if (result_ready) begin
                        grant <= '0;
                        ptr   <= id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_count_scheduler.sv
// Scoreboard bench for count_scheduler with a behavioural shared counter.
module tb_count_scheduler;

    localparam int NR  = 4;
    localparam int CW  = 13;
    localparam int MAX = 8191;

    typedef struct {
        int id;
        int val;
        int sat;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          tick = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] stop = '0;
    logic [CW-1:0] cnt_value;
    logic          cnt_full;
    logic          cnt_clr, cnt_run, result_sat, result_valid;
    logic          result_ready = 1'b1;
    logic [NR-1:0] grant;
    logic [CW-1:0] result;
    logic [2:0]    result_id;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    count_scheduler #(.NUM_REQ(NR), .CNT_W(CW), .MAX_COUNT(MAX)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .tick         (tick),
        .req          (req),
        .stop         (stop),
        .cnt_value    (cnt_value),
        .cnt_full     (cnt_full),
        .cnt_clr      (cnt_clr),
        .cnt_run      (cnt_run),
        .grant        (grant),
        .result       (result),
        .result_id    (result_id),
        .result_sat   (result_sat),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    always begin
        repeat (8) @(posedge clk);
        #1 tick = ~tick;
    end

    // Shared counter model
    always @(posedge clk or negedge resetn) begin
        if (!resetn)                          cnt_value <= '0;
        else if (cnt_clr)                     cnt_value <= '0;
        else if (cnt_run && cnt_value != MAX) cnt_value <= cnt_value + 1'b1;
    end
    assign cnt_full = (cnt_value == CW'(MAX));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    always @(negedge clk) begin
        if (resetn && result_valid && result_ready) begin
            if (sb.size() == 0) begin
                timeout("unexpected_result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_id", int'(result_id), e.id);
                check("result", int'(result), e.val);
                check("result_sat", int'(result_sat), e.sat);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        step();
        resetn = 1'b0; req = '0; stop = '0; result_ready = 1'b1;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic wait_grant(input int gid);
        int k = 0;
        do begin step(); k++; end while (grant == '0 && k < 40);
        if (grant == '0) timeout("wait_grant");
        check("grant", int'(grant), 1 << gid);
        check("cnt_clr_pulse", int'(cnt_clr), 1);
        step();
        check("cnt_clr_end", int'(cnt_clr), 0);
    endtask

    task automatic wait_run();
        int k = 0;
        while (!cnt_run && k < 40) begin step(); k++; end
        if (!cnt_run) timeout("wait_run");
        check("run_cnt_start", int'(cnt_value), 0);
    endtask

    task automatic wait_full();
        int k = 0;
        while (!cnt_full && k < 9000) begin step(); k++; end
        if (!cnt_full) timeout("wait_full");
    endtask

    task automatic wait_idle();
        int k = 0;
        while (result_valid && k < 40) begin step(); k++; end
        if (result_valid) timeout("wait_accept");
    endtask

    task automatic run_meas(input int gid, input int n);
        wait_grant(gid);
        wait_run();
        repeat (n) step();
        stop[gid] = 1'b1;
        sb.push_back('{gid, n, 0});
        step();
        stop = '0;
        check("cnt_run_after_stop", int'(cnt_run), 0);
        wait_idle();
    endtask

    int ids[5]  = '{0, 1, 2, 3, 0};
    int lens[5] = '{5, 17, 3, 42, 1};

    initial begin
        #12;
        check("rst_grant", int'(grant), 0);
        check("rst_cnt_run", int'(cnt_run), 0);
        check("rst_valid", int'(result_valid), 0);
        check("rst_cnt_clr", int'(cnt_clr), 0);
        apply_reset();

        // single requester, stop after 100 counts
        req = 4'b0001;
        run_meas(0, 100);
        req = '0;

        // all requesting: rotation 0,1,2,3,0
        apply_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) run_meas(ids[i], lens[i]);
        req = '0;

        // saturation
        req = 4'b0001;
        wait_grant(0);
        wait_run();
        sb.push_back('{0, MAX, 1});
        wait_full();
        step();
        check("sat_cnt_run_low", int'(cnt_run), 0);
        check("sat_valid", int'(result_valid), 1);
        wait_idle();
        req = '0;

        // stop coinciding with saturation
        req = 4'b0010;
        wait_grant(1);
        wait_run();
        wait_full();
        stop = 4'b0010;
        sb.push_back('{1, MAX, 0});
        step();
        stop = '0;
        wait_idle();
        req = '0;

        // abort from RUN, then rotation continues to 3
        req = 4'b1100;
        wait_grant(2);
        wait_run();
        repeat (4) step();
        req = 4'b1000;
        step();
        check("abort_cnt_run", int'(cnt_run), 0);
        check("abort_grant", int'(grant), 0);
        check("abort_valid", int'(result_valid), 0);
        run_meas(3, 7);
        req = '0;

        // backpressure stability, then async reset mid-RUN
        req = 4'b0001;
        result_ready = 1'b0;
        wait_grant(0);
        wait_run();
        repeat (30) step();
        stop = 4'b0001;
        sb.push_back('{0, 30, 0});
        step();
        stop = '0;
        for (int i = 0; i < 20; i++) begin
            check("hold_valid", int'(result_valid), 1);
            check("hold_result", int'(result), 30);
            check("hold_id", int'(result_id), 0);
            check("hold_sat", int'(result_sat), 0);
            step();
        end
        result_ready = 1'b1;
        step();
        check("accept_valid", int'(result_valid), 0);
        wait_grant(0);
        wait_run();
        repeat (10) step();
        #2 resetn = 1'b0;
        #1;
        check("areset_cnt_run", int'(cnt_run), 0);
        check("areset_grant", int'(grant), 0);
        check("areset_valid", int'(result_valid), 0);
        check("areset_result", int'(result), 0);
        check("areset_sat", int'(result_sat), 0);
        req = '0;
        step();
        resetn = 1'b1;
        repeat (20) step();
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
